// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: control codes,
// sequencing states and the shift-code classifier.
package alu_pkg;

   localparam int CTRL_W = 4;

   localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
   localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0001;
   localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0010;
   localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0011;
   localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0100;
   localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0101;
   localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b0110;
   localparam logic [CTRL_W-1:0] ALU_NOR  = 4'b0111;
   localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b1000;
   localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b1001;
   localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1010;

   localparam logic [CTRL_W-1:0] MAX_CTRL = ALU_SRA;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   function automatic logic is_shift(input logic [CTRL_W-1:0] ctrl);
      return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; the previous winner is held by the parent and
// loses any tie on the next arbitration.
module rr_arb2
   import alu_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters,
// one operation in flight, with operands, control and result registered.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int                DATA_W     = 32,
   parameter int                CTRL_W     = alu_pkg::CTRL_W,
   parameter bit                MASK_SHAMT = 1'b1,
   parameter logic [CTRL_W-1:0] MAX_CTRL   = alu_pkg::MAX_CTRL
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_op1,
   input  logic [DATA_W-1:0] req0_op2,
   input  logic [CTRL_W-1:0] req0_ctrl,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_data,
   output logic              rsp0_err,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_op1,
   input  logic [DATA_W-1:0] req1_op2,
   input  logic [CTRL_W-1:0] req1_ctrl,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_data,
   output logic              rsp1_err,
   output logic [DATA_W-1:0] alu_op1,
   output logic [DATA_W-1:0] alu_op2,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [DATA_W-1:0] alu_result,
   output logic              busy
);

   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_grant_q, last_grant_d;
   logic [DATA_W-1:0]   op1_q, op1_d;
   logic [DATA_W-1:0]   op2_q, op2_d;
   logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_err_q, rsp_err_d;

   logic [1:0]          grant;
   logic [DATA_W-1:0]   sel_op1;
   logic [DATA_W-1:0]   sel_op2;
   logic [DATA_W-1:0]   op2_masked;
   logic [CTRL_W-1:0]   sel_ctrl;

   rr_arb2 u_rr_arb2 (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant_q),
      .grant      (grant)
   );

   // Shift amount masking is applied at capture so the ALU sees a plain register.
   always_comb begin
      sel_op1    = grant[1] ? req1_op1  : req0_op1;
      sel_op2    = grant[1] ? req1_op2  : req0_op2;
      sel_ctrl   = grant[1] ? req1_ctrl : req0_ctrl;
      op2_masked = '0;
      op2_masked[4:0] = sel_op2[4:0];

      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      op1_d        = op1_q;
      op2_d        = op2_q;
      ctrl_d       = ctrl_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;

      case (state_q)
         ST_IDLE: begin
            if (grant != 2'b00) begin
               state_d      = ST_EXEC;
               owner_d      = grant[1];
               last_grant_d = grant[1];
               op1_d        = sel_op1;
               ctrl_d       = sel_ctrl;
               if (MASK_SHAMT && is_shift(sel_ctrl)) begin
                  op2_d = op2_masked;
               end else begin
                  op2_d = sel_op2;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            state_d    = ST_RESP;
            rsp_data_d = alu_result;
            rsp_err_d  = (ctrl_q > MAX_CTRL);
         end
         ST_RESP: begin
            if (owner_q ? rsp1_ready : rsp0_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; last_grant resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         op1_q        <= '0;
         op2_q        <= '0;
         ctrl_q       <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         ctrl_q       <= ctrl_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign req0_ready = !reset && (state_q == ST_IDLE) && grant[0];
   assign req1_ready = !reset && (state_q == ST_IDLE) && grant[1];

   assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
   assign rsp1_valid = (state_q == ST_RESP) &&  owner_q;
   assign rsp0_data  = rsp_data_q;
   assign rsp1_data  = rsp_data_q;
   assign rsp0_err   = rsp_err_q;
   assign rsp1_err   = rsp_err_q;

   assign alu_op1  = op1_q;
   assign alu_op2  = op2_q;
   assign alu_ctrl = ctrl_q;
   assign busy     = (state_q != ST_IDLE);

endmodule
